regfile_write_arbiter: RTL and testbench

//  Shares the register bank's single write port (writeReg/rc/write) between NUM_REQ

---
 rtl/regfile_write_arbiter_pkg.sv | 10 +
 rtl/regfile_write_arbiter_if.sv | 28 ++
 rtl/regfile_write_arbiter_rr.sv | 27 ++
 rtl/regfile_write_arbiter.sv | 66 ++++++
 tb/tb_regfile_write_arbiter.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_write_arbiter_pkg: shared sizes, requester indices and register index type
package regfile_arb_pkg;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int NUM_REQ = 3;
    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;
    localparam int REQ_CSR = 2;
    typedef logic [ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: writeback requests, decode reserve/hazard lookup and bank write port; master = requesters/decode/bank side, slave = arbiter
interface regfile_write_arbiter_if import regfile_arb_pkg::*; #(
    parameter int NUM_REQ = regfile_arb_pkg::NUM_REQ,
    parameter int DATA_W  = regfile_arb_pkg::DATA_W,
    parameter int ADDR_W  = regfile_arb_pkg::ADDR_W
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      reserve_valid;
    logic [ADDR_W-1:0]         reserve_addr;
    logic [ADDR_W-1:0]         check_addr_a;
    logic [ADDR_W-1:0]         check_addr_b;
    logic                      hazard_a;
    logic                      hazard_b;
    logic                      writeReg;
    logic [ADDR_W-1:0]         rc;
    logic [DATA_W-1:0]         write;
    modport master (
        output req_valid, req_addr, req_data, reserve_valid, reserve_addr, check_addr_a, check_addr_b,
        input  req_ready, hazard_a, hazard_b, writeReg, rc, write
    );
    modport slave (
        input  req_valid, req_addr, req_data, reserve_valid, reserve_addr, check_addr_a, check_addr_b,
        output req_ready, hazard_a, hazard_b, writeReg, rc, write
    );
endinterface

// File: rtl/regfile_write_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick; ports req_i, ptr_i (search start) -> gnt_o one-hot, gnt_idx_o
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] gnt_idx_o
);
    logic found;
    int   j;
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!found && req_i[j]) begin
                found     = 1'b1;
                gnt_o[j]  = 1'b1;
                gnt_idx_o = PW'(j);
            end
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin share of the bank write port with registered write stage and pending-write scoreboard
// Ports: clock_i, reset_i (sync active-high), bus (slave modport of regfile_write_arbiter_if).
// Build option REGFILE_ZERO_GUARD_EN: register 0 is hardwired zero (no write, no reservation, no hazard).
module regfile_write_arbiter import regfile_arb_pkg::*; #(
    parameter int NUM_REQ = regfile_arb_pkg::NUM_REQ,
    parameter int DATA_W  = regfile_arb_pkg::DATA_W,
    parameter int ADDR_W  = regfile_arb_pkg::ADDR_W
) (
    input logic clock_i,
    input logic reset_i,
    regfile_write_arbiter_if.slave bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef REGFILE_ZERO_GUARD_EN
    localparam bit ZG = 1'b1;
`else
    localparam bit ZG = 1'b0;
`endif
    logic [NUM_REQ-1:0]     gnt;
    logic [PW-1:0]          gnt_idx, ptr_q, ptr_d;
    logic [ADDR_W-1:0]      g_addr, rc_q;
    logic [DATA_W-1:0]      g_data, write_q;
    logic [2**ADDR_W-1:0]   pend_q, pend_d;
    logic                   xfer, wr_en, res_en, wr_q;
    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
        .req_i     (bus.req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );
    assign bus.req_ready = reset_i ? '0 : gnt;
    assign xfer          = !reset_i && |gnt;
    assign g_addr        = bus.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign g_data        = bus.req_data[int'(gnt_idx)*DATA_W +: DATA_W];
    assign wr_en         = xfer && (!ZG || g_addr != '0);
    assign res_en        = bus.reserve_valid && (!ZG || bus.reserve_addr != '0);
    assign ptr_d         = xfer ? ((int'(gnt_idx) == NUM_REQ-1) ? '0 : gnt_idx + PW'(1)) : ptr_q;
    // Set is applied after clear so a same-cycle reservation of the written register stays pending.
    always_comb begin
        pend_d = pend_q;
        if (xfer) pend_d[g_addr] = 1'b0;
        if (res_en) pend_d[bus.reserve_addr] = 1'b1;
    end
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ptr_q   <= '0;
            pend_q  <= '0;
            wr_q    <= 1'b0;
            rc_q    <= '0;
            write_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            pend_q <= pend_d;
            wr_q   <= wr_en;
            if (wr_en) begin
                rc_q    <= g_addr;
                write_q <= g_data;
            end
        end
    end
    assign bus.writeReg = wr_q;
    assign bus.rc       = rc_q;
    assign bus.write    = write_q;
    assign bus.hazard_a = pend_q[bus.check_addr_a];
    assign bus.hazard_b = pend_q[bus.check_addr_b];
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed self-checking bench for regfile_write_arbiter with a negedge bank model
module tb_regfile_write_arbiter;
    import regfile_arb_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [DATA_W-1:0] bank [2**ADDR_W];
    regfile_write_arbiter_if bus ();
    regfile_write_arbiter dut (.clock_i(clk), .reset_i(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(negedge clk) if (bus.writeReg) bank[bus.rc] <= bus.write;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic set_req(input int i, input reg_idx_t a, input logic [DATA_W-1:0] d);
        bus.req_addr[i*ADDR_W +: ADDR_W] = a;
        bus.req_data[i*DATA_W +: DATA_W] = d;
    endtask
    initial begin
        logic [2:0] exp_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        bus.req_valid = '1;
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.reserve_valid = 1'b0;
        bus.reserve_addr = '0;
        bus.check_addr_a = '0;
        bus.check_addr_b = '0;
        #1;
        chk("ready_in_reset", bus.req_ready, 0);
        tick();
        tick();
        chk("rst_writeReg", bus.writeReg, 0);
        chk("rst_rc", bus.rc, 0);
        chk("rst_write", bus.write, 0);
        rst = 1'b0;
        bus.req_valid = 3'b000;
        tick();
        chk("idle_writeReg", bus.writeReg, 0);
        chk("rst_hazard_a", bus.hazard_a, 0);
        // 1: single ALU write
        set_req(REQ_ALU, 5'd5, 32'hDEADBEEF);
        bus.req_valid = 3'b001;
        #1;
        chk("t1_ready", bus.req_ready, 3'b001);
        tick();
        bus.req_valid = 3'b000;
        chk("t1_writeReg", bus.writeReg, 1);
        chk("t1_rc", bus.rc, 5);
        chk("t1_write", bus.write, 32'hDEADBEEF);
        @(negedge clk);
        #1;
        chk("t1_bank5", bank[5], 32'hDEADBEEF);
        tick();
        chk("t1_idle_writeReg", bus.writeReg, 0);
        chk("t1_hold_rc", bus.rc, 5);
        // 2: all valid from pointer 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) set_req(i, reg_idx_t'(10 + i), 32'h100 + i);
        bus.req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("t2_ready%0d", c), bus.req_ready, exp_g[c]);
            tick();
            chk($sformatf("t2_writeReg%0d", c), bus.writeReg, 1);
            chk($sformatf("t2_rc%0d", c), bus.rc, 10 + (c % 3));
        end
        bus.req_valid = 3'b000;
        // 3: reserve then MEM clears
        bus.reserve_valid = 1'b1;
        bus.reserve_addr = 5'd7;
        tick();
        bus.reserve_valid = 1'b0;
        bus.check_addr_a = 5'd7;
        #1;
        chk("t3_hazard_set", bus.hazard_a, 1);
        set_req(REQ_MEM, 5'd7, 32'h77);
        bus.req_valid = 3'b010;
        #1;
        chk("t3_ready", bus.req_ready, 3'b010);
        tick();
        bus.req_valid = 3'b000;
        chk("t3_hazard_clr", bus.hazard_a, 0);
        chk("t3_rc", bus.rc, 7);
        // 4: same-addr set wins; different addrs both apply
        bus.reserve_valid = 1'b1;
        bus.reserve_addr = 5'd9;
        set_req(REQ_ALU, 5'd9, 32'h99);
        bus.req_valid = 3'b001;
        #1;
        chk("t4_ready9", bus.req_ready, 3'b001);
        tick();
        bus.req_valid = 3'b000;
        bus.check_addr_a = 5'd9;
        #1;
        chk("t4_pend9", bus.hazard_a, 1);
        bus.reserve_addr = 5'd4;
        tick();
        bus.reserve_addr = 5'd3;
        set_req(REQ_CSR, 5'd4, 32'h44);
        bus.req_valid = 3'b100;
        bus.check_addr_b = 5'd4;
        #1;
        chk("t4_pend4_before", bus.hazard_b, 1);
        chk("t4_ready4", bus.req_ready, 3'b100);
        tick();
        bus.reserve_valid = 1'b0;
        bus.req_valid = 3'b000;
        bus.check_addr_a = 5'd3;
        #1;
        chk("t4_pend3", bus.hazard_a, 1);
        chk("t4_pend4", bus.hazard_b, 0);
        // 5: reset right after a transfer
        bus.check_addr_b = 5'd9;
        set_req(REQ_ALU, 5'd15, 32'hF);
        bus.req_valid = 3'b001;
        tick();
        chk("t5_writeReg_pre", bus.writeReg, 1);
        bus.req_valid = 3'b000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_writeReg", bus.writeReg, 0);
        chk("t5_hazard_a", bus.hazard_a, 0);
        chk("t5_hazard_b", bus.hazard_b, 0);
        bus.req_valid = 3'b111;
        #1;
        chk("t5_ready", bus.req_ready, 3'b001);
        // 6: register 0 handling
        bus.req_valid = 3'b001;
        set_req(REQ_ALU, 5'd0, 32'h1);
        #1;
        chk("t6_ready", bus.req_ready, 3'b001);
        tick();
        bus.req_valid = 3'b000;
        bus.reserve_valid = 1'b1;
        bus.reserve_addr = 5'd0;
        bus.check_addr_a = 5'd0;
`ifdef REGFILE_ZERO_GUARD_EN
        chk("t6_writeReg", bus.writeReg, 0);
        tick();
        bus.reserve_valid = 1'b0;
        chk("t6_hazard0", bus.hazard_a, 0);
`else
        chk("t6_writeReg", bus.writeReg, 1);
        chk("t6_rc", bus.rc, 0);
        chk("t6_write", bus.write, 1);
        tick();
        bus.reserve_valid = 1'b0;
        chk("t6_hazard0", bus.hazard_a, 1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
